// File: rtl/rcc_pkg.sv
// rcc_pkg: shared constants and count type for the ripple carry counter
package rcc_pkg;
    localparam int RCC_DEFAULT_WIDTH = 4;
    typedef logic [RCC_DEFAULT_WIDTH-1:0] rcc_count_t;
endpackage

// File: rtl/t_ff.sv
// t_ff: falling-edge toggle flip-flop with asynchronous active-low clear
module t_ff (
    input  logic clk,
    input  logic rst,
    output logic q
);
    logic q_q;
    logic q_d;
    always_comb q_d = ~q_q;
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) q_q <= 1'b0;
        else      q_q <= q_d;
    end
    assign q = q_q;
endmodule

// File: rtl/ripple_carry_counter.sv
// ripple_carry_counter: chained toggle-flop up-counter; RCC_TC_EN adds the all-ones tc flag
module ripple_carry_counter
    import rcc_pkg::*;
#(
    parameter int WIDTH = RCC_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
`ifdef RCC_TC_EN
    output logic             tc,
`endif
    output logic [WIDTH-1:0] q
);
    typedef logic [WIDTH-1:0] count_t;
    count_t stage_q;
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        if (i == 0) begin : g_first
            t_ff u_tff (.clk(clk), .rst(rst), .q(stage_q[i]));
        end else begin : g_next
            // each stage is clocked by the falling edge of the stage below
            t_ff u_tff (.clk(stage_q[i-1]), .rst(rst), .q(stage_q[i]));
        end
    end
    assign q = stage_q;
`ifdef RCC_TC_EN
    assign tc = &stage_q;
`endif
endmodule

// File: tb/tb_ripple_carry_counter.sv
// tb_ripple_carry_counter: vector table plus scoreboard checks of 4-, 1- and 8-bit counters
module tb_ripple_carry_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] q;
    logic [0:0] q1;
    logic [7:0] q8;
    int         checks = 0;
    int         errors = 0;
    int         cnt8 = 0;
    logic [3:0] exp_q[$];
`ifdef RCC_TC_EN
    logic tc, tc1, tc8;
    ripple_carry_counter #(.WIDTH(4)) dut   (.clk(clk), .rst(rst), .tc(tc),  .q(q));
    ripple_carry_counter #(.WIDTH(1)) dut_1 (.clk(clk), .rst(rst), .tc(tc1), .q(q1));
    ripple_carry_counter #(.WIDTH(8)) dut_8 (.clk(clk), .rst(rst), .tc(tc8), .q(q8));
`else
    ripple_carry_counter #(.WIDTH(4)) dut   (.clk(clk), .rst(rst), .q(q));
    ripple_carry_counter #(.WIDTH(1)) dut_1 (.clk(clk), .rst(rst), .q(q1));
    ripple_carry_counter #(.WIDTH(8)) dut_8 (.clk(clk), .rst(rst), .q(q8));
`endif
    always #5 clk = ~clk;
    typedef struct packed {
        logic       r;
        logic [3:0] e;
    } vec_t;
    vec_t vecs[$];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic step(input logic r, input logic [3:0] e);
        logic [3:0] x;
        rst = r;
        exp_q.push_back(e);
        cnt8 = r ? (cnt8 + 1) % 256 : 0;
        @(negedge clk);
        #1;
        x = exp_q.pop_front();
        chk("q", 32'(q), 32'(x));
        chk("q_w1", 32'(q1), 32'(x[0]));
        chk("q_w8", 32'(q8), 32'(cnt8));
`ifdef RCC_TC_EN
        chk("tc", 32'(tc), 32'(x == 4'hF));
        chk("tc_w1", 32'(tc1), 32'(x[0]));
        chk("tc_w8", 32'(tc8), 32'(cnt8 == 255));
`endif
    endtask
    initial begin
        for (int k = 0; k < 3; k++) vecs.push_back('{r: 1'b0, e: 4'h0});
        for (int k = 1; k <= 17; k++) vecs.push_back('{r: 1'b1, e: 4'(k)});
        #1;
        chk("reset_t0", 32'(q), 32'h0);
        foreach (vecs[n]) step(vecs[n].r, vecs[n].e);
        // rising edge must not disturb the settled value
        @(posedge clk);
        #1;
        chk("rise_hold", 32'(q), 32'h1);
        step(1'b0, 4'h0);
        for (int k = 1; k <= 6; k++) step(1'b1, 4'(k));
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst", 32'(q), 32'h0);
        chk("async_rst_w8", 32'(q8), 32'h0);
        cnt8 = 0;
        step(1'b1, 4'h1);
        step(1'b0, 4'h0);
        for (int k = 1; k <= 20; k++) step(1'b1, 4'(k));
        chk("long_final", 32'(q), 32'h4);
        step(1'b0, 4'h0);
        for (int k = 1; k <= 256; k++) begin
            step(1'b1, 4'(k));
            if (k == 255) chk("w8_ff", 32'(q8), 32'hFF);
        end
        chk("w8_wrap", 32'(q8), 32'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
